// File: rtl/adc_scan_sched.sv
// adc_scan_sched: masked channel-scan scheduler in front of adc_ctrl with a per-channel result bank.
// Build with `define ADC_SCAN_ALARM_EN to add sticky per-channel threshold alarms.

module adc_scan_slot #(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
`ifdef ADC_SCAN_ALARM_EN
    input  logic [DATA_W-1:0] alarm_thr,
    input  logic              alarm_clr,
    output logic              alarm,
`endif
    output logic [DATA_W-1:0] data,
    output logic              valid
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (wr_en) begin
            data  <= wr_data;
            valid <= 1'b1;
        end
    end

`ifdef ADC_SCAN_ALARM_EN
    // A store above threshold beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n)
            alarm <= 1'b0;
        else if (wr_en && (wr_data > alarm_thr))
            alarm <= 1'b1;
        else if (alarm_clr)
            alarm <= 1'b0;
    end
`endif

endmodule

module adc_scan_sched #(
    parameter int CH_NUM      = 8,
    parameter int DATA_W      = 12,
    parameter int PERIOD_W    = 16,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_scan_start,
    input  logic                       i_scan_stop,
    input  logic                       i_cont_mode,
    input  logic [CH_NUM-1:0]          i_ch_mask,
    input  logic [PERIOD_W-1:0]        i_period,
    output logic [$clog2(CH_NUM)-1:0]  o_ADC_addr,
    output logic                       o_ADC_En,
    input  logic                       i_ADC_Done,
    input  logic [DATA_W-1:0]          i_ADC_Data,
    input  logic [$clog2(CH_NUM)-1:0]  i_rd_ch,
    output logic [DATA_W-1:0]          o_rd_data,
    output logic [CH_NUM-1:0]          o_ch_valid,
    output logic                       o_new_sample,
    output logic [$clog2(CH_NUM)-1:0]  o_new_ch,
    output logic                       o_scan_done,
    output logic                       o_busy,
`ifdef ADC_SCAN_ALARM_EN
    input  logic [DATA_W-1:0]          i_alarm_thr,
    input  logic                       i_alarm_clr,
    output logic [CH_NUM-1:0]          o_alarm,
`endif
    output logic                       o_timeout_err
);

    localparam int CH_W  = $clog2(CH_NUM);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEL   = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_STORE = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    logic [2:0]                     state;
    logic [CH_W-1:0]                ch_ptr;
    logic [CH_NUM-1:0]              mask_q;
    logic                           cont_q;
    logic [TMO_W-1:0]               tmo_cnt;
    logic [PERIOD_W-1:0]            gap_cnt;
    logic [DATA_W-1:0]              adc_data_q;
    logic                           timeout_err;
    logic                           new_sample;
    logic [CH_W-1:0]                new_ch;
    logic                           scan_done;
    logic [DATA_W-1:0]              rd_data;
    logic [CH_NUM-1:0][DATA_W-1:0]  bank;
    logic [CH_NUM-1:0]              ch_valid;
    logic [CH_NUM-1:0]              wr_en;

    logic                           last_ch;
    logic                           cont_eff;
    logic [2:0]                     adv_state;
    logic [CH_W-1:0]                adv_ptr;
    logic                           adv_done;
    logic                           adv_relatch;

    assign last_ch  = (ch_ptr == CH_W'(CH_NUM - 1));
    assign cont_eff = cont_q & ~i_scan_stop;

    // Where the FSM goes once the current channel is finished (skipped, stored or timed out).
    always_comb begin
        adv_state   = S_SEL;
        adv_ptr     = ch_ptr + 1'b1;
        adv_done    = 1'b0;
        adv_relatch = 1'b0;
        if (last_ch) begin
            adv_done = 1'b1;
            adv_ptr  = '0;
            if (!cont_eff)
                adv_state = S_IDLE;
            else if (i_period == '0) begin
                adv_state   = S_SEL;
                adv_relatch = 1'b1;
            end else
                adv_state = S_GAP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ch_ptr      <= '0;
            mask_q      <= '0;
            cont_q      <= 1'b0;
            tmo_cnt     <= '0;
            gap_cnt     <= '0;
            adc_data_q  <= '0;
            timeout_err <= 1'b0;
            new_sample  <= 1'b0;
            new_ch      <= '0;
            scan_done   <= 1'b0;
        end else begin
            new_sample <= 1'b0;
            scan_done  <= 1'b0;
            if (i_scan_stop)
                cont_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_scan_start) begin
                        mask_q      <= i_ch_mask;
                        cont_q      <= i_cont_mode & ~i_scan_stop;
                        ch_ptr      <= '0;
                        timeout_err <= 1'b0;
                        state       <= S_SEL;
                    end
                end
                S_SEL: begin
                    if (mask_q[ch_ptr])
                        state <= S_START;
                    else begin
                        state     <= adv_state;
                        ch_ptr    <= adv_ptr;
                        scan_done <= adv_done;
                        gap_cnt   <= PERIOD_W'(1);
                        if (adv_relatch)
                            mask_q <= i_ch_mask;
                    end
                end
                S_START: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_ADC_Done) begin
                        adc_data_q <= i_ADC_Data;
                        state      <= S_STORE;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                        // Give up on this channel; bank and valid bit stay as they were.
                        timeout_err <= 1'b1;
                        state       <= adv_state;
                        ch_ptr      <= adv_ptr;
                        scan_done   <= adv_done;
                        gap_cnt     <= PERIOD_W'(1);
                        if (adv_relatch)
                            mask_q <= i_ch_mask;
                    end else
                        tmo_cnt <= tmo_cnt + 1'b1;
                end
                S_STORE: begin
                    new_sample <= 1'b1;
                    new_ch     <= ch_ptr;
                    state      <= adv_state;
                    ch_ptr     <= adv_ptr;
                    scan_done  <= adv_done;
                    gap_cnt    <= PERIOD_W'(1);
                    if (adv_relatch)
                        mask_q <= i_ch_mask;
                end
                S_GAP: begin
                    if (i_scan_stop)
                        state <= S_IDLE;
                    else if (gap_cnt >= i_period) begin
                        mask_q <= i_ch_mask;
                        ch_ptr <= '0;
                        state  <= S_SEL;
                    end else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_en = '0;
        if (state == S_STORE)
            wr_en[ch_ptr] = 1'b1;
    end

    for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
        adc_scan_slot #(.DATA_W(DATA_W)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_en     (wr_en[n]),
            .wr_data   (adc_data_q),
`ifdef ADC_SCAN_ALARM_EN
            .alarm_thr (i_alarm_thr),
            .alarm_clr (i_alarm_clr),
            .alarm     (o_alarm[n]),
`endif
            .data      (bank[n]),
            .valid     (ch_valid[n])
        );
    end

    // Registered read; a same-cycle write is seen one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n)
            rd_data <= '0;
        else
            rd_data <= bank[i_rd_ch];
    end

    assign o_ADC_addr    = ch_ptr;
    assign o_ADC_En      = (state == S_START);
    assign o_busy        = (state != S_IDLE);
    assign o_rd_data     = rd_data;
    assign o_ch_valid    = ch_valid;
    assign o_new_sample  = new_sample;
    assign o_new_ch      = new_ch;
    assign o_scan_done   = scan_done;
    assign o_timeout_err = timeout_err;

endmodule

// File: tb/tb_adc_scan_sched.sv
// Self-checking bench for adc_scan_sched: table of single-shot scans plus hand-written
// continuous, stop, reset-mid-conversion and (optional) alarm sequences.

module tb_adc_scan_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_scan_start = 1'b0;
    logic        i_scan_stop = 1'b0;
    logic        i_cont_mode = 1'b0;
    logic [7:0]  i_ch_mask = '0;
    logic [15:0] i_period = '0;
    logic [2:0]  o_ADC_addr;
    logic        o_ADC_En;
    logic        i_ADC_Done = 1'b0;
    logic [11:0] i_ADC_Data = '0;
    logic [2:0]  i_rd_ch = '0;
    logic [11:0] o_rd_data;
    logic [7:0]  o_ch_valid;
    logic        o_new_sample;
    logic [2:0]  o_new_ch;
    logic        o_scan_done;
    logic        o_busy;
    logic        o_timeout_err;
`ifdef ADC_SCAN_ALARM_EN
    logic [11:0] i_alarm_thr = '0;
    logic        i_alarm_clr = 1'b0;
    logic [7:0]  o_alarm;
`endif

    adc_scan_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_scan_start  (i_scan_start),
        .i_scan_stop   (i_scan_stop),
        .i_cont_mode   (i_cont_mode),
        .i_ch_mask     (i_ch_mask),
        .i_period      (i_period),
        .o_ADC_addr    (o_ADC_addr),
        .o_ADC_En      (o_ADC_En),
        .i_ADC_Done    (i_ADC_Done),
        .i_ADC_Data    (i_ADC_Data),
        .i_rd_ch       (i_rd_ch),
        .o_rd_data     (o_rd_data),
        .o_ch_valid    (o_ch_valid),
        .o_new_sample  (o_new_sample),
        .o_new_ch      (o_new_ch),
        .o_scan_done   (o_scan_done),
        .o_busy        (o_busy),
`ifdef ADC_SCAN_ALARM_EN
        .i_alarm_thr   (i_alarm_thr),
        .i_alarm_clr   (i_alarm_clr),
        .o_alarm       (o_alarm),
`endif
        .o_timeout_err (o_timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [2:0]  ch;
        logic [11:0] data;
    } res_t;

    typedef struct {
        logic [7:0] mask;
        logic [7:0] silent;
        int         exp_en;
        logic [7:0] exp_valid;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    res_t        exp_q[$];
    logic [2:0]  en_q[$];
    int          en_times[$];
    int          en_cnt = 0;
    int          done_cnt = 0;
    bit          no_store = 1'b0;
    logic [7:0]  silent_mask = '0;
    bit          ovr_en = 1'b0;
    logic [11:0] ovr_data [8];
    logic [2:0]  m_ch;
    logic [11:0] m_dat;
    res_t        m_r;
    res_t        mon_r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ADC model: Done with data 40 cycles after each En, except for silent channels.
    initial begin
        forever begin
            tick();
            if (o_ADC_En === 1'b1) begin
                m_ch = o_ADC_addr;
                en_cnt++;
                en_times.push_back(cyc);
                if (en_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL en_order: unexpected En for ch %0d", m_ch);
                end else
                    chk("en_order", {29'd0, m_ch}, {29'd0, en_q.pop_front()});
                if (!silent_mask[m_ch]) begin
                    m_dat = ovr_en ? ovr_data[m_ch] : (12'hA00 + {9'd0, m_ch});
                    repeat (40) tick();
                    chk("addr_stable", {29'd0, o_ADC_addr}, {29'd0, m_ch});
                    i_ADC_Done = 1'b1;
                    i_ADC_Data = m_dat;
                    m_r.ch = m_ch;
                    m_r.data = m_dat;
                    exp_q.push_back(m_r);
                    tick();
                    i_ADC_Done = 1'b0;
                    i_ADC_Data = 12'h5A5;
                end
            end
        end
    end

    // Store monitor: every stored result must match the oldest conversion the model returned.
    initial begin
        forever begin
            tick();
            if (o_scan_done === 1'b1) done_cnt++;
            if (o_new_sample === 1'b1) begin
                if (no_store || exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_store: ch %0d stored, none expected", o_new_ch);
                end else begin
                    mon_r = exp_q.pop_front();
                    chk("store_ch", {29'd0, o_new_ch}, {29'd0, mon_r.ch});
                    chk("store_valid", {31'd0, o_ch_valid[mon_r.ch]}, 32'd1);
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        en_q.delete();
        en_times.delete();
        en_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic start_scan(input logic [7:0] mask, input logic cont, output int t0);
        i_ch_mask = mask;
        i_cont_mode = cont;
        t0 = cyc;
        i_scan_start = 1'b1;
        tick();
        i_scan_start = 1'b0;
    endtask

    task automatic push_order(input logic [7:0] mask);
        for (int c = 0; c < 8; c++)
            if (mask[c]) en_q.push_back(3'(c));
    endtask

    task automatic wait_done(input int t0, input int budget, output int lat);
        lat = -1;
        for (int k = 0; k < budget; k++) begin
            if (o_scan_done === 1'b1) begin
                lat = cyc - t0;
                break;
            end
            tick();
        end
        if (lat < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scan_done_wait: no o_scan_done within %0d cycles", budget);
        end
    endtask

    task automatic wait_en(input int n, input int budget);
        for (int k = 0; k < budget && en_times.size() < n; k++) tick();
        if (en_times.size() < n) begin
            n_vec++;
            n_err++;
            $display("FAIL en_wait: got %0d En pulses, expected %0d", en_times.size(), n);
        end
    endtask

    task automatic chk_rd(input string name, input logic [2:0] ch, input logic [11:0] exp);
        i_rd_ch = ch;
        tick();
        chk(name, {20'd0, o_rd_data}, {20'd0, exp});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        chk({tag, "_en"}, {31'd0, o_ADC_En}, 32'd0);
        chk({tag, "_addr"}, {29'd0, o_ADC_addr}, 32'd0);
        chk({tag, "_valid"}, {24'd0, o_ch_valid}, 32'd0);
        chk({tag, "_new_sample"}, {31'd0, o_new_sample}, 32'd0);
        chk({tag, "_new_ch"}, {29'd0, o_new_ch}, 32'd0);
        chk({tag, "_scan_done"}, {31'd0, o_scan_done}, 32'd0);
        chk({tag, "_timeout"}, {31'd0, o_timeout_err}, 32'd0);
        chk({tag, "_rd_data"}, {20'd0, o_rd_data}, 32'd0);
    endtask

    vec_t vt[5];
    int   t0, lat, sep_a, sep_b, sep100, sep20, t3;

    initial begin
        // lat = 9 SEL cycles + 42 per converted channel (START + 40 WAIT + STORE), 4096 per timeout
        vt[0] = '{8'h25, 8'h00, 3, 8'h25, 1'b0, 135};
        vt[1] = '{8'h00, 8'h00, 0, 8'h00, 1'b0, 9};
        vt[2] = '{8'h18, 8'h08, 2, 8'h10, 1'b1, 4147};
        vt[3] = '{8'hFF, 8'h00, 8, 8'hFF, 1'b0, 345};
        vt[4] = '{8'h80, 8'h00, 1, 8'h80, 1'b0, 51};

        do_reset();
        chk_all_zero("reset");

        for (int i = 0; i < 5; i++) begin
            do_reset();
            silent_mask = vt[i].silent;
            push_order(vt[i].mask);
            start_scan(vt[i].mask, 1'b0, t0);
            wait_done(t0, 5000, lat);
            chk($sformatf("v%0d_scan_lat", i), lat, vt[i].exp_lat);
            tick();
            chk($sformatf("v%0d_busy", i), {31'd0, o_busy}, 32'd0);
            chk($sformatf("v%0d_valid", i), {24'd0, o_ch_valid}, {24'd0, vt[i].exp_valid});
            chk($sformatf("v%0d_timeout", i), {31'd0, o_timeout_err}, {31'd0, vt[i].exp_err});
            chk($sformatf("v%0d_en_cnt", i), en_cnt, vt[i].exp_en);
            chk($sformatf("v%0d_pending", i), exp_q.size() + en_q.size(), 0);
            repeat (5) tick();
            chk($sformatf("v%0d_done_cnt", i), done_cnt, 1);
            for (int c = 0; c < 8; c++)
                chk_rd($sformatf("v%0d_bank%0d", i, c), 3'(c),
                       vt[i].exp_valid[c] ? (12'hA00 + 12'(c)) : 12'h000);
        end
        silent_mask = '0;

        // Continuous mode, period 100, stopped during the gap.
        do_reset();
        i_period = 16'd100;
        repeat (3) en_q.push_back(3'd0);
        start_scan(8'h01, 1'b1, t0);
        wait_en(3, 1000);
        if (en_times.size() >= 3) begin
            sep_a = en_times[1] - en_times[0];
            sep_b = en_times[2] - en_times[1];
            chk("cont_periodic", sep_b, sep_a);
            sep100 = sep_b;
            t3 = en_times[2];
            while (cyc < t3 + 80) tick();
            chk("cont_gap_busy", {31'd0, o_busy}, 32'd1);
            i_scan_stop = 1'b1;
            tick();
            i_scan_stop = 1'b0;
            chk("stop_gap_busy", {31'd0, o_busy}, 32'd0);
            chk("cont_done_cnt", done_cnt, 3);
            chk("cont_valid", {24'd0, o_ch_valid}, 32'h01);
        end

        // Continuous mode, period 20, stopped during a conversion: that scan still finishes.
        do_reset();
        i_period = 16'd20;
        repeat (3) en_q.push_back(3'd0);
        start_scan(8'h01, 1'b1, t0);
        wait_en(3, 1000);
        if (en_times.size() >= 3) begin
            sep20 = en_times[2] - en_times[1];
            i_scan_stop = 1'b1;
            tick();
            i_scan_stop = 1'b0;
            chk("stop_wait_busy", {31'd0, o_busy}, 32'd1);
            for (int k = 0; k < 200 && o_busy; k++) tick();
            chk("stop_wait_idle", {31'd0, o_busy}, 32'd0);
            repeat (100) tick();
            chk("stop_wait_en_cnt", en_cnt, 3);
            chk("stop_wait_pending", exp_q.size(), 0);
            chk("period_delta", sep100 - sep20, 80);
            chk("period_sep_range", (sep100 >= 141 && sep100 <= 160) ? 1 : 0, 1);
        end
        i_cont_mode = 1'b0;
        i_period = '0;

        // Reset in the middle of WAIT; the model's late Done must be ignored.
        do_reset();
        en_q.push_back(3'd0);
        start_scan(8'h01, 1'b0, t0);
        wait_en(1, 50);
        repeat (10) tick();
        no_store = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_all_zero("midrst");
        repeat (40) tick();
        chk("stray_valid", {24'd0, o_ch_valid}, 32'd0);
        chk("stray_busy", {31'd0, o_busy}, 32'd0);
        chk_rd("stray_bank0", 3'd0, 12'h000);
        no_store = 1'b0;
        exp_q.delete();
        en_q.push_back(3'd0);
        start_scan(8'h01, 1'b0, t0);
        wait_done(t0, 500, lat);
        chk("rescan_lat", lat, 51);
        tick();
        chk("rescan_valid", {24'd0, o_ch_valid}, 32'h01);
        chk_rd("rescan_bank0", 3'd0, 12'hA00);

`ifdef ADC_SCAN_ALARM_EN
        do_reset();
        chk("alarm_reset", {24'd0, o_alarm}, 32'd0);
        i_alarm_thr = 12'h800;
        ovr_en = 1'b1;
        ovr_data[1] = 12'h801;
        ovr_data[2] = 12'h800;
        push_order(8'h06);
        start_scan(8'h06, 1'b0, t0);
        wait_done(t0, 500, lat);
        tick();
        chk("alarm_set", {24'd0, o_alarm}, 32'h02);
        i_alarm_clr = 1'b1;
        tick();
        i_alarm_clr = 1'b0;
        chk("alarm_clr", {24'd0, o_alarm}, 32'h00);
        ovr_en = 1'b0;
`endif

        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
